cell_mem_scheduler: RTL and testbench
=====================================

CELL_MEM_SCHEDULER -- requirements
Module: cell_mem_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 96, particle word width, {posz, posy, posx}.
- ADDR_WIDTH, 8, cell memory address width.
- PARTICLE_NUM, 220, cell memory depth in words.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock for the block.
- reset_n, in, 1, asynchronous active-low reset.
- rd_start, in, 1, request to stream the whole cell.
- rd_valid, out, 1, rd_data/rd_index valid.
- rd_data, out, DATA_WIDTH, particle position.
- rd_index, out, ADDR_WIDTH, particle address (1..N).
- rd_last, out, 1, final particle of the stream.
- rd_done, out, 1, one-cycle pulse at end of stream.
- rd_busy, out, 1, a read sequence is in progress.
- cnt_err, out, 1, sticky flag: stored count exceeded PARTICLE_NUM-1.
- wr_req, in, 1, write request; held until wr_ack.
- wr_addr, in, ADDR_WIDTH, write address.
- wr_data, in, DATA_WIDTH, write data.
- wr_ack, out, 1, one-cycle pulse in the cycle mem_wren is high.
- mem_address, out, ADDR_WIDTH, to cell memory.
- mem_data, out, DATA_WIDTH, to cell memory.
- mem_rden, out, 1, to cell memory.
- mem_wren, out, 1, to cell memory.
- mem_q, in, DATA_WIDTH, from cell memory; 2-cycle read latency.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have the states IDLE, CNT_ISSUE, CNT_WAIT1, CNT_WAIT2, STREAM, DRAIN1, DRAIN2 and WRITE.
REQ-005 In IDLE, the FSM SHALL move to WRITE if wr_req is high, else to CNT_ISSUE if rd_start or the pending flag is set, else stay in IDLE.
- Writes have priority over reads.
REQ-006 A rd_start sampled while the block is not in IDLE, or while a write wins arbitration, SHALL set a one-deep pending flag.
- Further rd_start pulses while the flag is set are dropped.
- The flag clears on entry to CNT_ISSUE.
REQ-007 WRITE SHALL last one cycle.
- mem_wren=1, mem_rden=0, mem_address=wr_addr, mem_data=wr_data, wr_ack=1.
- Then return to IDLE; wr_req is re-arbitrated only from IDLE.
REQ-008 CNT_ISSUE SHALL drive mem_address=0 and mem_rden=1, then pass through CNT_WAIT1 and CNT_WAIT2.
REQ-009 In CNT_WAIT2 the block SHALL capture N=mem_q[ADDR_WIDTH-1:0].
- If N>PARTICLE_NUM-1, N is clamped to PARTICLE_NUM-1 and cnt_err is set.
- If N=0, the block pulses rd_done with no rd_valid and returns to IDLE.
REQ-010 STREAM SHALL issue addresses 1..N, one per cycle, with mem_rden=1.
- A tag pipeline (valid, index, last) two stages deep tracks each issue.
- The final issue moves the FSM to DRAIN1, then DRAIN2, then IDLE.
REQ-011 rd_valid, rd_index and rd_last SHALL be the tag pipeline outputs, and rd_data SHALL equal mem_q, all aligned in the same cycle.
REQ-012 rd_done SHALL pulse in the same cycle as rd_last.
REQ-013 Cycle timing, with rd_start sampled at edge T:
- mem_rden for address 0 high in cycle T+1.
- First issue (address 1) in cycle T+4.
- First rd_valid in cycle T+6.
- rd_last in cycle T+5+N.
- IDLE in cycle T+6+N.
REQ-014 rd_busy SHALL be high from CNT_ISSUE through DRAIN2 inclusive.
REQ-015 The consumer SHALL accept every rd_valid beat; the block applies no backpressure.
REQ-016 mem_rden and mem_wren SHALL never be high in the same cycle.
REQ-017 mem_data SHALL be 0 when mem_wren is low.

Reset
REQ-018 While reset_n is low, the FSM SHALL be in IDLE and all outputs, the pending flag, the tag pipeline, N and cnt_err SHALL be 0.
REQ-019 A reset asserted mid-sequence SHALL abort the sequence immediately.
- No rd_done or rd_last is produced for the aborted stream.
- In-flight tags are discarded.

Structure
REQ-020 The FSM state encoding and the count-address constant (0) SHALL reside in the shared package alongside the existing MD defines.
REQ-021 The two-stage tag pipeline SHALL be one sub-module, cell_rd_tag_pipe, parameterized by ADDR_WIDTH.

Verification
REQ-022 The bench SHALL cover, with a 2-cycle-latency RAM model:
- Cell count 5, rd_start at T -> rd_valid T+6..T+10 with rd_index 1..5 and data from words 1..5; rd_last and rd_done at T+10; rd_busy low at T+11.
- Cell count 0 -> rd_done at T+4, no rd_valid, back to IDLE.
- Cell count 250 -> cnt_err=1 and exactly 219 beats.
- wr_req and rd_start in the same cycle -> write in the next cycle with wr_ack; the read starts afterwards with the same timing shifted by 2 cycles.
- Two rd_start pulses during a stream -> exactly one additional stream.
- reset_n low during STREAM -> outputs 0 at once; a later rd_start streams correctly.

Source files
------------

// File: rtl/cell_mem_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// cell_mem_scheduler_pkg
// Shared definitions for the MD cell-memory blocks.
//   - MD_* constants: default particle word layout and cell memory geometry.
//   - CNT_ADDR: cell memory word that holds the particle count of the cell.
//   - sched_state_t: state encoding of the cell memory scheduler FSM.
//   - clamp_count(): limits a stored particle count to the usable range.
// No ports (package).
// -----------------------------------------------------------------------------
package cell_mem_scheduler_pkg;

    // MD defines: one particle word is {posz, posy, posx}, 32 bits each.
    localparam int MD_COORD_WIDTH  = 32;
    localparam int MD_DATA_WIDTH   = 3 * MD_COORD_WIDTH;
    localparam int MD_ADDR_WIDTH   = 8;
    localparam int MD_PARTICLE_NUM = 220;

    // Word 0 of every cell holds the particle count; particles live at 1..N.
    localparam int CNT_ADDR = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CNT_ISSUE = 3'd1,
        CNT_WAIT1 = 3'd2,
        CNT_WAIT2 = 3'd3,
        STREAM    = 3'd4,
        DRAIN1    = 3'd5,
        DRAIN2    = 3'd6,
        WRITE     = 3'd7
    } sched_state_t;

    // Word 0 is the count itself, so a cell of depth D holds at most D-1
    // particles; anything larger is corrupt and gets clamped.
    function automatic int clamp_count(input int raw, input int max_count);
        return (raw > max_count) ? max_count : raw;
    endfunction

endpackage

// File: rtl/cell_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// cell_rd_tag_pipe
// Two-stage tag pipeline that tracks each read issued to the cell memory so
// the tag (valid, index, last) lines up with the 2-cycle-latency read data.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   in_valid/in_index/in_last: tag of the read issued this cycle
//   mid_last                 : stage-1 tag is a valid final beat
//   out_valid/out_index/out_last : stage-2 tag, aligned with memory q
// -----------------------------------------------------------------------------
module cell_rd_tag_pipe #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_index,
    input  logic                  in_last,
    output logic                  mid_last,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_index;
    logic                  s1_last;

    // Index and last are qualified by valid so idle stages always read as 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_index  <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_index  <= in_valid ? in_index : '0;
            s1_last   <= in_valid & in_last;
            out_valid <= s1_valid;
            out_index <= s1_index;
            out_last  <= s1_last;
        end
    end

    assign mid_last = s1_last;

endmodule

// File: rtl/cell_mem_scheduler.sv
// -----------------------------------------------------------------------------
// cell_mem_scheduler
// Arbitrates a single-port cell memory between a write port and a read
// sequencer that streams a whole cell: it reads the particle count at word 0,
// then issues reads of words 1..N and presents each word with its index.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   rd_start            : request to stream the cell (one-deep pending queue)
//   rd_valid/rd_data/rd_index/rd_last : streamed particle beats, no backpressure
//   rd_done             : one-cycle pulse at end of stream (with rd_last)
//   rd_busy             : read sequence in progress
//   cnt_err             : sticky, stored count exceeded PARTICLE_NUM-1
//   wr_req/wr_addr/wr_data/wr_ack : write port; wr_req held until wr_ack
//   mem_address/mem_data/mem_rden/mem_wren/mem_q : cell memory, 2-cycle read
// Handshake: wr_req is a level request that the requester holds until it sees
// wr_ack, which pulses for exactly the cycle in which mem_wren is high.
// Read beats are push-only: the consumer must take every rd_valid beat.
// Timing (rd_start sampled at edge T, cycle T+k follows edge T+k-1):
//   count read T+1, first issue T+4, first beat T+6, last beat T+5+N.
// -----------------------------------------------------------------------------
module cell_mem_scheduler
    import cell_mem_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH   = MD_DATA_WIDTH,
    parameter int ADDR_WIDTH   = MD_ADDR_WIDTH,
    parameter int PARTICLE_NUM = MD_PARTICLE_NUM
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  rd_start,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  rd_last,
    output logic                  rd_done,
    output logic                  rd_busy,
    output logic                  cnt_err,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CNT  = ADDR_WIDTH'(CNT_ADDR);

    sched_state_t          state;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] cell_count;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  issue_valid;
    logic                  issue_last;
    logic                  tag_mid_last;

    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] clamped_count;
    logic                  count_over;

    // The count word arrives on mem_q during CNT_WAIT2.
    assign raw_count     = mem_q[ADDR_WIDTH-1:0];
    assign clamped_count = ADDR_WIDTH'(clamp_count(int'(raw_count), PARTICLE_NUM - 1));
    assign count_over    = (clamped_count != raw_count);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            cell_count  <= '0;
            cur_addr    <= '0;
            cnt_err     <= 1'b0;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            wr_ack      <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            issue_valid <= 1'b0;
            issue_last  <= 1'b0;
        end else begin
            // Memory strobes and pulses default low; mem_data is zero
            // whenever no write is being driven.
            wr_ack      <= 1'b0;
            mem_wren    <= 1'b0;
            mem_rden    <= 1'b0;
            mem_data    <= '0;
            mem_address <= '0;
            issue_valid <= 1'b0;
            issue_last  <= 1'b0;
            // End of a non-empty stream: done lands with rd_last because both
            // come out of the same tag stage.
            rd_done     <= tag_mid_last;

            // A request that cannot start now is remembered once; extra
            // requests while one is already remembered are dropped.
            if (rd_start && (state != IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state       <= WRITE;
                        wr_ack      <= 1'b1;
                        mem_wren    <= 1'b1;
                        mem_address <= wr_addr;
                        mem_data    <= wr_data;
                        if (rd_start) begin
                            pending <= 1'b1;
                        end
                    end else if (rd_start || pending) begin
                        state       <= CNT_ISSUE;
                        pending     <= 1'b0;
                        mem_rden    <= 1'b1;
                        mem_address <= ADDR_CNT;
                        rd_busy     <= 1'b1;
                    end
                end
                CNT_ISSUE: state <= CNT_WAIT1;
                CNT_WAIT1: state <= CNT_WAIT2;
                CNT_WAIT2: begin
                    cell_count <= clamped_count;
                    if (count_over) begin
                        cnt_err <= 1'b1;
                    end
                    if (clamped_count == '0) begin
                        // Empty cell: finish without any beats.
                        state   <= IDLE;
                        rd_busy <= 1'b0;
                        rd_done <= 1'b1;
                    end else begin
                        state       <= STREAM;
                        cur_addr    <= ADDR_ONE;
                        mem_rden    <= 1'b1;
                        mem_address <= ADDR_ONE;
                        issue_valid <= 1'b1;
                        issue_last  <= (clamped_count == ADDR_ONE);
                    end
                end
                STREAM: begin
                    // cur_addr is the address on the memory bus this cycle.
                    if (cur_addr == cell_count) begin
                        state <= DRAIN1;
                    end else begin
                        cur_addr    <= cur_addr + ADDR_ONE;
                        mem_rden    <= 1'b1;
                        mem_address <= cur_addr + ADDR_ONE;
                        issue_valid <= 1'b1;
                        issue_last  <= ((cur_addr + ADDR_ONE) == cell_count);
                    end
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    state   <= IDLE;
                    rd_busy <= 1'b0;
                end
                WRITE: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    rd_busy <= 1'b0;
                end
            endcase
        end
    end

    cell_rd_tag_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_tag_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (issue_valid),
        .in_index  (mem_address),
        .in_last   (issue_last),
        .mid_last  (tag_mid_last),
        .out_valid (rd_valid),
        .out_index (rd_index),
        .out_last  (rd_last)
    );

    // mem_q is the memory's output register; it is passed through only on a
    // valid beat so that rd_data reads 0 otherwise (including under reset).
    assign rd_data = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_cell_mem_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cell_mem_scheduler
// Self-checking bench for cell_mem_scheduler with a 2-cycle-latency RAM model.
// Stimulus pushes expected beats/done pulses into queues; a monitor process
// pops and compares whenever the DUT presents a beat or a done pulse.
// -----------------------------------------------------------------------------
module tb_cell_mem_scheduler;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
    localparam int EW = 32 + 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          rd_start;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_index;
    logic          rd_last;
    logic          rd_done;
    logic          rd_busy;
    logic          cnt_err;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    cell_mem_scheduler #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PARTICLE_NUM (PN)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_start    (rd_start),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_index    (rd_index),
        .rd_last     (rd_last),
        .rd_done     (rd_done),
        .rd_busy     (rd_busy),
        .cnt_err     (cnt_err),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // ---------------- RAM model: 2-cycle read latency ----------------
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_p1;
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) ram_p1 <= ram[mem_address];
        mem_q <= ram_p1;
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            done_q[$];
    int            total = 0;
    int            bad = 0;
    int            viol_both = 0;
    int            viol_data = 0;
    int            viol_last = 0;

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] x, y, z;
        x = 32'h1000_0000 + 32'(i);
        y = 32'h00A5_0000 ^ (32'(i) << 4);
        z = 32'hC0DE_0000 + 32'(i * 7);
        return {z, y, x};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_beat(input int at_cyc, input int k, input logic last);
        exp_q.push_back({32'(at_cyc), last, AW'(k), pat(k)});
    endtask

    // t1 is the cycle right after the edge that sampled rd_start (count read).
    task automatic expect_stream(input int t1, input int n);
        for (int k = 1; k <= n; k++) push_beat(t1 + 4 + k, k, k == n);
        if (n == 0) done_q.push_back(t1 + 3);
        else        done_q.push_back(t1 + 4 + n);
    endtask

    task automatic monitor();
        logic [EW-1:0] e;
        int            dc;
        forever begin
            @(negedge clock);
            if (mem_rden && mem_wren) viol_both++;
            if (!mem_wren && (mem_data != '0)) viol_data++;
            if (rd_last && !rd_valid) viol_last++;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected: got index %0d at cycle %0d, required no beat", rd_index, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_cycle", 128'(cyc), 128'(e[EW-1:DW+AW+1]));
                    check("beat_index", 128'(rd_index), 128'(e[DW+AW-1:DW]));
                    check("beat_last",  128'(rd_last), 128'(e[DW+AW]));
                    check("beat_data",  128'(rd_data), 128'(e[DW-1:0]));
                end
            end
            if (rd_done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got rd_done at cycle %0d, required none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    check("done_cycle", 128'(cyc), 128'(dc));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clock);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        do begin
            @(negedge clock);
            n++;
        end while (!wr_ack && n < 10);
        check("wr_ack_bus", 128'({wr_ack, mem_wren, mem_rden, mem_address}), 128'({1'b1, 1'b1, 1'b0, a}));
        check("wr_bus_data", 128'(mem_data), 128'(d));
        wr_req = 1'b0;
    endtask

    task automatic start_read(output int t1);
        @(negedge clock);
        rd_start = 1'b1;
        @(negedge clock);
        rd_start = 1'b0;
        t1 = cyc;
        check("cnt_read", 128'({mem_rden, mem_address, rd_busy}), 128'({1'b1, AW'(0), 1'b1}));
    endtask

    task automatic wait_idle(input int exp_cyc);
        int got;
        got = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (!rd_busy) begin
                got = cyc;
                break;
            end
        end
        check("busy_fall", 128'(got), 128'(exp_cyc));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t1;
        reset_n  = 1'b0;
        rd_start = 1'b0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_ctrl", 128'({rd_valid, rd_done, rd_busy, cnt_err, rd_last, wr_ack, mem_rden, mem_wren}), 128'(0));
        check("reset_addr", 128'({rd_index, mem_address}), 128'(0));
        check("reset_mem_data", 128'(mem_data), 128'(0));
        check("reset_rd_data", 128'(rd_data), 128'(0));
        reset_n = 1'b1;

        // Load particle words through the write port
        for (int i = 1; i < PN; i++) write_word(AW'(i), pat(i));

        // Cell count 5
        write_word(AW'(0), DW'(5));
        start_read(t1);
        expect_stream(t1, 5);
        repeat (3) @(negedge clock);
        check("first_issue", 128'({mem_rden, mem_address}), 128'({1'b1, AW'(1)}));
        wait_idle(t1 + 10);

        // Empty cell
        write_word(AW'(0), DW'(0));
        start_read(t1);
        expect_stream(t1, 0);
        wait_idle(t1 + 3);
        check("cnt_err_clear", 128'(cnt_err), 128'(0));

        // Oversized count: clamp to PN-1 beats
        write_word(AW'(0), DW'(250));
        start_read(t1);
        expect_stream(t1, PN - 1);
        wait_idle(t1 + 5 + PN - 1);
        check("cnt_err_set", 128'(cnt_err), 128'(1));

        // Write and read requested in the same cycle: write first
        @(negedge clock);
        wr_req   = 1'b1;
        wr_addr  = AW'(0);
        wr_data  = DW'(3);
        rd_start = 1'b1;
        @(negedge clock);
        t1 = cyc;
        check("collide_write", 128'({wr_ack, mem_wren, mem_rden, mem_address}), 128'({1'b1, 1'b1, 1'b0, AW'(0)}));
        check("collide_wdata", 128'(mem_data), 128'(3));
        wr_req   = 1'b0;
        rd_start = 1'b0;
        expect_stream(t1 + 2, 3);
        repeat (2) @(negedge clock);
        check("collide_cnt_read", 128'({mem_rden, mem_wren, mem_address}), 128'({1'b1, 1'b0, AW'(0)}));
        wait_idle(t1 + 2 + 5 + 3);

        // Two rd_start pulses during a stream -> one extra stream
        write_word(AW'(0), DW'(4));
        start_read(t1);
        expect_stream(t1, 4);
        repeat (5) @(negedge clock);
        rd_start = 1'b1;
        @(negedge clock);
        rd_start = 1'b0;
        @(negedge clock);
        rd_start = 1'b1;
        @(negedge clock);
        rd_start = 1'b0;
        wait_idle(t1 + 9);
        expect_stream(t1 + 10, 4);
        wait_idle(t1 + 19);
        repeat (6) @(negedge clock);
        check("no_third_stream", 128'(rd_busy), 128'(0));

        // Reset during STREAM aborts the sequence
        write_word(AW'(0), DW'(6));
        start_read(t1);
        push_beat(t1 + 5, 1, 1'b0);
        push_beat(t1 + 6, 2, 1'b0);
        repeat (6) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("abort_ctrl", 128'({rd_valid, rd_done, rd_busy, rd_last, mem_rden, cnt_err}), 128'(0));
        check("abort_bus", 128'({rd_index, mem_address}), 128'(0));
        check("abort_rd_data", 128'(rd_data), 128'(0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        start_read(t1);
        expect_stream(t1, 6);
        wait_idle(t1 + 11);

        // Final bookkeeping
        repeat (10) @(negedge clock);
        check("beats_left", 128'(exp_q.size()), 128'(0));
        check("dones_left", 128'(done_q.size()), 128'(0));
        check("rden_wren_overlap", 128'(viol_both), 128'(0));
        check("mem_data_idle", 128'(viol_data), 128'(0));
        check("last_without_valid", 128'(viol_last), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
